// File: rtl/bcd2_scan_driver.sv
// bcd2_scan_driver
// Latches a two-digit BCD value (ones/tens) and time-multiplexes it onto a
// common-anode 4-digit seven-segment display. Only digit positions 0 and 1
// are driven; an[3:2] are held dark. The scan rate comes from an internal
// prescaler. A leading zero in the tens digit can optionally be blanked.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   ones      BCD ones digit (captured when in_valid = 1)
//   tens      BCD tens digit (captured when in_valid = 1)
//   in_valid  load strobe
//   en        display enable (0 = all anodes off)
//   an        anodes, active-low; an[0] = ones, an[1] = tens
//   seg       segments, active-low, {g,f,e,d,c,b,a}
//   phase     current scan phase (0 = ones, 1 = tens)

module bcd2_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic       in_valid,
    input  logic       en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       phase
);

    localparam int unsigned DIG_W = 4;
    localparam int unsigned AN_W  = 4;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [AN_W-1:0]  AN_OFF    = 4'b1111;
    localparam logic [AN_W-1:0]  AN_ONES   = 4'b1110;
    localparam logic [AN_W-1:0]  AN_TENS   = 4'b1101;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

    typedef enum logic {
        PH_ONES = 1'b0,
        PH_TENS = 1'b1
    } phase_t;

    phase_t             r_phase;
    phase_t             w_phase_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIG_W-1:0]   r_ones;
    logic [DIG_W-1:0]   r_tens;
    logic [AN_W-1:0]    r_an;
    logic [SEG_W-1:0]   r_seg;
    logic [AN_W-1:0]    w_an_nxt;
    logic [SEG_W-1:0]   w_seg_nxt;
    logic               w_wrap;

    // BCD to active-low gfedcba; codes 10..15 show a dash
    function automatic logic [SEG_W-1:0] f_decode(input logic [DIG_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Digit capture register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ones <= '0;
            r_tens <= '0;
        end else if (in_valid) begin
            r_ones <= ones;
            r_tens <= tens;
        end
    end

    // Refresh prescaler; free-running regardless of en
    assign w_wrap = (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Scan phase state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase <= PH_ONES;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Scan phase next-state: toggle on prescaler wrap
    always_comb begin
        w_phase_nxt = r_phase;
        if (w_wrap) begin
            case (r_phase)
                PH_ONES: w_phase_nxt = PH_TENS;
                PH_TENS: w_phase_nxt = PH_ONES;
                default: w_phase_nxt = PH_ONES;
            endcase
        end
    end

    // Anode/segment selection from current phase and latched digits
    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_BLANK;
        if (en) begin
            case (r_phase)
                PH_ONES: begin
                    w_an_nxt  = AN_ONES;
                    w_seg_nxt = f_decode(r_ones);
                end
                PH_TENS: begin
                    // Only a genuine zero blanks; illegal codes still show a dash
                    if (!(BLANK_LZ && (r_tens == '0))) begin
                        w_an_nxt  = AN_TENS;
                        w_seg_nxt = f_decode(r_tens);
                    end
                end
                default: begin
                    w_an_nxt  = AN_OFF;
                    w_seg_nxt = SEG_BLANK;
                end
            endcase
        end
    end

    // Output register: one cycle behind phase and captured data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign phase = r_phase;

endmodule

// File: tb/tb_bcd2_scan_driver.sv
// Testbench for bcd2_scan_driver: three instances sharing stimulus
// (blanking on, blanking off, REFRESH_DIV = 1) compared cycle by cycle
// against a behavioural model of the display.

module tb_bcd2_scan_driver;

    localparam int unsigned DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       in_valid;
    logic       en;

    logic [3:0] an_b,  an_n,  an_1;
    logic [6:0] seg_b, seg_n, seg_1;
    logic       ph_b,  ph_n,  ph_1;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: latched digits and edges elapsed since last reset edge
    int m_ones;
    int m_tens;
    int m_k;

    bcd2_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) u_dut_blank (
        .clk(clk), .rst_n(rst_n), .ones(ones), .tens(tens),
        .in_valid(in_valid), .en(en), .an(an_b), .seg(seg_b), .phase(ph_b));

    bcd2_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) u_dut_noblank (
        .clk(clk), .rst_n(rst_n), .ones(ones), .tens(tens),
        .in_valid(in_valid), .en(en), .an(an_n), .seg(seg_n), .phase(ph_n));

    bcd2_scan_driver #(.REFRESH_DIV(1), .BLANK_LZ(1'b1)) u_dut_div1 (
        .clk(clk), .rst_n(rst_n), .ones(ones), .tens(tens),
        .in_valid(in_valid), .en(en), .an(an_1), .seg(seg_1), .phase(ph_1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (d < 10) ? tbl[d] : 7'b0111111;
    endfunction

    // Expected {an,seg} for a given displayed phase, digits and enable
    function automatic logic [10:0] disp(input int ph, input int o, input int t,
                                         input bit e, input bit blank);
        if (!e) return {4'b1111, 7'b1111111};
        if (ph == 0) return {4'b1110, seg_of(o)};
        if (blank && t == 0) return {4'b1111, 7'b1111111};
        return {4'b1101, seg_of(t)};
    endfunction

    // Drive one cycle of inputs, advance one clock edge and check all outputs
    task automatic tick(input bit rst, input bit iv, input int o, input int t, input bit e);
        logic [10:0] exp_b, exp_n, exp_1;
        int          ph_exp, ph1_exp;
        rst_n    = ~rst;
        in_valid = iv;
        ones     = 4'(o);
        tens     = 4'(t);
        en       = e;
        if (rst) begin
            exp_b  = {4'b1111, 7'b1111111};
            exp_n  = exp_b;
            exp_1  = exp_b;
            m_ones = 0;
            m_tens = 0;
            m_k    = 0;
        end else begin
            exp_b = disp((m_k / DIV) % 2, m_ones, m_tens, e, 1'b1);
            exp_n = disp((m_k / DIV) % 2, m_ones, m_tens, e, 1'b0);
            exp_1 = disp(m_k % 2, m_ones, m_tens, e, 1'b1);
            if (iv) begin
                m_ones = o;
                m_tens = t;
            end
            m_k++;
        end
        ph_exp  = (m_k / DIV) % 2;
        ph1_exp = m_k % 2;
        @(posedge clk);
        #1;
        check("an_blank",    32'(an_b),  32'(exp_b[10:7]));
        check("seg_blank",   32'(seg_b), 32'(exp_b[6:0]));
        check("phase_blank", 32'(ph_b),  32'(ph_exp));
        check("an_noblank",  32'(an_n),  32'(exp_n[10:7]));
        check("seg_noblank", 32'(seg_n), 32'(exp_n[6:0]));
        check("phase_noblank", 32'(ph_n), 32'(ph_exp));
        check("an_div1",     32'(an_1),  32'(exp_1[10:7]));
        check("seg_div1",    32'(seg_1), 32'(exp_1[6:0]));
        check("phase_div1",  32'(ph_1),  32'(ph1_exp));
    endtask

    initial begin
        m_ones = 0;
        m_tens = 0;
        m_k    = 0;
        rst_n = 1'b0; in_valid = 1'b0; ones = '0; tens = '0; en = 1'b0;
        @(negedge clk);

        // Reset hold with a strobe present: digit must not be captured
        for (int i = 0; i < 3; i++) tick(1, 1, 5, 0, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 1);

        // Value 36
        tick(0, 1, 6, 3, 1);
        for (int i = 0; i < 18; i++) tick(0, 0, 0, 0, 1);

        // Value 13 then reload 57 during a ones phase
        tick(0, 1, 3, 1, 1);
        while ((m_k / DIV) % 2 != 0 || (m_k % DIV) != 1) tick(0, 0, 0, 0, 1);
        tick(0, 1, 7, 5, 1);
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 0, 1);

        // Leading zero: 09
        tick(0, 1, 9, 0, 1);
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 0, 1);

        // Illegal BCD on both digits, then disable
        tick(0, 1, 12, 10, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 0, 0);

        // Reset in phase 1 at cnt = 2
        tick(0, 1, 8, 4, 1);
        while (!((m_k / DIV) % 2 == 1 && (m_k % DIV) == 2)) tick(0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 1);

        // Capture coinciding with a phase toggle
        while ((m_k % DIV) != DIV - 1) tick(0, 0, 0, 0, 1);
        tick(0, 1, 2, 6, 1);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd2_scan_driver.md
Name: bcd2_scan_driver

Overview:
- Downstream consumer of the 6-bit binary-to-BCD converter.
- Latches its `ones`/`tens` BCD digits and time-multiplexes them onto a common-anode 4-digit seven-segment display. Only digit positions 0 and 1 are used.
- Generates the refresh scan internally from a clock prescaler.
- Optionally blanks a leading zero in the tens digit.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit phase; legal range ≥ 1. Simulation benches use 4.
- BLANK_LZ, 1: 1 = tens digit is dark when `tens_r` == 0; 0 = zero is shown.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ones  input  4  BCD ones digit from the converter.
- tens  input  4  BCD tens digit from the converter.
- in_valid  input  1  load strobe; digits are captured on any edge where it is high.
- en  input  1  display enable; 0 = all anodes off.
- an  output  4  anodes, active-low. an[0] = ones, an[1] = tens, an[3:2] are always 1.
- seg  output  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- phase  output  1  current scan phase: 0 = ones, 1 = tens. Intended for debug and verification.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - `ones_r` = 0, `tens_r` = 0, prescaler `cnt` = 0, `phase` = 0.
  - an = 4'b1111, seg = 7'b1111111.
  - Reset takes priority over every other input. Asserting it mid-scan returns to phase 0 with `cnt` = 0 on that edge.
- Capture: at an edge with in_valid = 1, `ones_r` <= ones and `tens_r` <= tens. There is no back-pressure; back-to-back strobes each overwrite the previous value.
- Prescaler:
  - `cnt` counts 0 .. REFRESH_DIV-1 and wraps to 0.
  - On the wrap edge, `phase` toggles.
  - `cnt` runs regardless of en.
  - With REFRESH_DIV = 1, `phase` toggles every cycle.
- Output register: an and seg are registered from the current `phase`, `ones_r`, `tens_r` and en. They therefore lag `phase`, and captured data, by exactly 1 cycle.
  - Example: `phase` toggles at edge N, so an/seg reflect the new phase at edge N+1.
  - Example: a digit captured at edge N appears on seg at edge N+1 at the earliest, if that digit's phase is active.
- Anode selection:
  - en = 0: an = 4'b1111 and seg = 7'b1111111.
  - phase 0: an = 4'b1110, seg = decode(`ones_r`).
  - phase 1: an = 4'b1101, seg = decode(`tens_r`).
  - phase 1 with BLANK_LZ = 1 and `tens_r` == 0: an = 4'b1111, seg = 7'b1111111.
- Decode (gfedcba, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Illegal BCD (10–15) decodes to a dash, 0111111 (segment g only). This applies to both digits; a 0 test on an illegal tens value does not blank.
- Simultaneous events: an in_valid capture on the same edge as a phase toggle is legal. The next edge outputs the new phase with the new data.
- No combinational path from any input to an or seg.

Test Plan:
1. Reset and hold. Stimulus: rst_n = 0 for 3 cycles with in_valid = 1, ones = 5. Required: an = 1111, seg = 1111111, phase = 0 throughout. After release, the first phase-0 output shows seg = 1000000 (digit 0), because the digit was not captured during reset.
2. Converter value 36 (6'b100100). Stimulus: ones = 6, tens = 3, in_valid pulse, en = 1, REFRESH_DIV = 4. Required: an alternates 1110/1101 every 4 cycles; seg = 0000010 with 1110 and 0110000 with 1101; the phase-to-output lag is exactly 1 cycle.
3. Value 13 then 57. Stimulus: load 1/3, then reload 7/5 mid-phase-0. Required: seg changes from 0110000 to 1111000 exactly 1 cycle after the capture edge; the next tens phase shows 0010010.
4. Leading-zero blanking. Stimulus: tens = 0, ones = 9, BLANK_LZ = 1. Required: the tens phase gives an = 1111; the ones phase gives seg = 0010000. Repeat with BLANK_LZ = 0: the tens phase gives an = 1101, seg = 1000000.
5. Illegal BCD and enable. Stimulus: ones = 4'hC, tens = 4'hA. Required: both phases show seg = 0111111. Then drop en to 0: 1 cycle later an = 1111, and `phase` keeps toggling every 4 cycles.
6. Reset mid-scan. Stimulus: assert rst_n = 0 at `cnt` = 2 in phase 1. Required: on the next edge phase = 0, `cnt` = 0, an = 1111, and the digits are cleared to 0.
